rd_resp_buffer: RTL and testbench
=================================

# rd_resp_buffer

Read-response buffer sitting directly downstream of the APB read path (`rd_valid`/`rd_data` from the APB top level). Captures every read-data beat into a small FIFO, tags it with a wrapping sequence number, and presents it to a consumer over a valid/ready handshake. It also counts beats dropped on overflow and flags a sticky error when the read-increment-write loop's data stream stops progressing as it should.

## Interface
- `DEPTH`, default 8: buffer entries; power of two, ≥2.
- `DATA_W`, default 32: read-data width.
- `CNT_W`, default 8: width of the sequence tag and the overflow counter.

- `clk`, input, 1: sole clock; all logic on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `rd_valid_i`, input, 1: read beat present this cycle; each high cycle is one beat.
- `rd_data_i`, input, DATA_W: read data, qualified by `rd_valid_i`.
- `out_valid_o`, output, 1: head entry available.
- `out_ready_i`, input, 1: consumer accepts head entry.
- `out_data_o`, output, DATA_W: head data; 0 when `out_valid_o`=0.
- `out_seq_o`, output, CNT_W: head sequence tag; 0 when `out_valid_o`=0.
- `level_o`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full_o`, output, 1: `level_o`==DEPTH.
- `overflow_cnt_o`, output, CNT_W: dropped-beat count; saturates at all-ones.
- `seq_err_o`, output, 1: sticky data-progression error.
- `err_clr_i`, input, 1: synchronous clear of `overflow_cnt_o` and `seq_err_o`.

## Operation
- Storage: DEPTH×(DATA_W+CNT_W) array, with read/write pointers of $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
- Tag counter `seq_q`:
  - Increments by 1 (mod 2^CNT_W) on every `rd_valid_i` cycle, whether the beat is accepted or dropped.
  - A beat is stored with the pre-increment value, so dropped beats appear as gaps in `out_seq_o`.
- Pop: `pop = out_valid_o & out_ready_i`. `out_ready_i` while empty has no effect.
- Push: `push = rd_valid_i & (~full_o | pop)`. When full, a beat is accepted only if a pop occurs in the same cycle.
- Drop: `rd_valid_i & full_o & ~pop`. The beat is discarded and `overflow_cnt_o` increments, saturating at 2^CNT_W−1.
- Progression check:
  - State: register `last_q` plus flag `seen_q`.
  - Applies to every `rd_valid_i` cycle, including dropped beats. If `seen_q`=1 and `rd_data_i` equals neither `last_q` nor `last_q+1` (mod 2^DATA_W), set `seq_err_o`.
  - After every such cycle, `last_q`←`rd_data_i` and `seen_q`←1.
- `err_clr_i` clears `overflow_cnt_o` and `seq_err_o`. A same-cycle increment or error event wins: the counter becomes 1, or `seq_err_o` stays 1.
- `err_clr_i` does not affect FIFO contents, `seq_q`, `last_q` or `seen_q`.

## Timing
- Reset (`reset_n`=0, asynchronous) zeroes: pointers, `seq_q`, `last_q`, `seen_q`, `overflow_cnt_o`, `seq_err_o`. Consequently `out_valid_o`=0, `level_o`=0, `full_o`=0, `out_data_o`=0, `out_seq_o`=0.
- Storage array is not reset.
- Reset mid-stream discards all buffered entries. The first beat after release is tag 0 and is exempt from the progression check.
- Latency: a beat pushed at edge N appears on `out_valid_o`/`out_data_o` after edge N. There is no same-cycle bypass when empty.
- `out_data_o`/`out_seq_o` are combinational reads of the head entry, gated by `out_valid_o`.
- `out_data_o`/`out_seq_o` hold stable while `out_valid_o`=1 and `out_ready_i`=0.
- `level_o` and `full_o` are derived from the registered pointers, so they update after the edge.
- Simultaneous push and pop leaves `level_o` unchanged; this includes the full case.
- Pointers wrap naturally; the wrap bit toggles every DEPTH operations.

## Test plan
- **Reset, then single beat.** Pulse `rd_valid_i`=1 with data 0x5 for one cycle, `out_ready_i`=0. Required: next cycle `out_valid_o`=1, `out_data_o`=0x5, `out_seq_o`=0, `level_o`=1. Then raise `out_ready_i` for one cycle; required: `level_o`=0, `out_data_o`=0.
- **Fill and overflow** (DEPTH=8). Send 10 consecutive beats with data 0..9, `out_ready_i`=0. Required:
  - `full_o`=1 and `level_o`=8.
  - `overflow_cnt_o`=2.
  - Draining yields data 0..7 with tags 0..7.
  - A following beat has tag 10.
- **Full with simultaneous push/pop.** Fill to 8 entries, then hold `out_ready_i`=1 and send one beat. Required: `level_o` stays 8, `overflow_cnt_o` unchanged, and the new beat sits at the tail.
- **Progression check.**
  - Beats 0x10, 0x10, 0x11 keep `seq_err_o`=0.
  - Next beat 0x13 sets `seq_err_o`=1, and it stays set.
  - `err_clr_i` pulse clears it.
  - `last_q` wrap 0xFFFFFFFF→0x0 does not set the error.
- **Saturation and clear priority** (CNT_W=4). Force 20 drops. Required: `overflow_cnt_o`=0xF. Then `err_clr_i` in the same cycle as a drop: required `overflow_cnt_o`=1.
- **Wrap-around and reset mid-stream.**
  - Stream 300 beats with `out_ready_i`=1 throughout. Required: every tag delivered in order, modulo 256, and no drops.
  - Assert `reset_n`=0 with 3 entries held. Required: immediate `out_valid_o`=0 and `level_o`=0.
  - After release, the next beat has tag 0 and no error.

Source files
------------

// File: rtl/rd_resp_buffer.sv
// Read-response buffer: queues read-data beats with a wrapping sequence tag,
// hands them to a consumer over valid/ready, counts overflow drops and flags
// breaks in the read-increment-write data progression.
module rd_resp_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_valid_i,
  input  logic [DATA_W-1:0]        rd_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CNT_W-1:0]         out_seq_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic [CNT_W-1:0]         overflow_cnt_o,
  output logic                     seq_err_o,
  input  logic                     err_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [CNT_W-1:0]  mem_seq  [DEPTH];

  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]  seq_q;
  logic [DATA_W-1:0] last_q;
  logic              seen_q;

  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic err_evt;

  // Occupancy and handshake decode from the registered pointers
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level_o     = wr_ptr_q - rd_ptr_q;
    out_valid_o = ~empty;
    pop         = out_valid_o & out_ready_i;
    push        = rd_valid_i & (~full_o | pop);
    drop        = rd_valid_i & full_o & ~pop;
    err_evt     = rd_valid_i & seen_q &
                  (rd_data_i != last_q) &&
                  (rd_data_i != (last_q + DATA_W'(1)));
  end

  // Head entry, forced to zero while the buffer is empty
  always_comb begin
    out_data_o = '0;
    out_seq_o  = '0;
    if (out_valid_o) begin
      out_data_o = mem_data[rd_ptr_q[AW-1:0]];
      out_seq_o  = mem_seq[rd_ptr_q[AW-1:0]];
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q[AW-1:0]] <= rd_data_i;
      mem_seq[wr_ptr_q[AW-1:0]]  <= seq_q;
    end
  end

  // Pointers and sequence tag; tag advances on every beat, dropped or not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
    end else begin
      if (push)       wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)        rd_ptr_q <= rd_ptr_q + PW'(1);
      if (rd_valid_i) seq_q    <= seq_q + CNT_W'(1);
    end
  end

  // Progression tracker: remembers the previous beat's data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
      seen_q <= 1'b0;
    end else if (rd_valid_i) begin
      last_q <= rd_data_i;
      seen_q <= 1'b1;
    end
  end

  // Saturating drop counter; a drop coinciding with clear leaves a count of 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt_o <= '0;
    end else if (drop) begin
      if (err_clr_i)                overflow_cnt_o <= CNT_W'(1);
      else if (overflow_cnt_o != '1) overflow_cnt_o <= overflow_cnt_o + CNT_W'(1);
    end else if (err_clr_i) begin
      overflow_cnt_o <= '0;
    end
  end

  // Sticky progression error; a new error event beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seq_err_o <= 1'b0;
    else          seq_err_o <= err_evt | (seq_err_o & ~err_clr_i);
  end

endmodule

// File: tb/tb_rd_resp_buffer.sv
// Directed bench for rd_resp_buffer: a default instance (DEPTH 8, 8-bit tags)
// and a 4-bit-counter instance for saturation behaviour.
module tb_rd_resp_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_seq;
  logic [3:0]  level;
  logic        full;
  logic [7:0]  ovf_cnt;
  logic        seq_err;

  logic        b_valid = 1'b0;
  logic [31:0] b_data = 32'h7;
  logic        b_ready = 1'b0;
  logic        b_clr = 1'b0;
  logic        b_out_valid;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_seq;
  logic [3:0]  b_level;
  logic        b_full;
  logic [3:0]  b_ovf_cnt;
  logic        b_seq_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rd_resp_buffer #(.DEPTH(8), .DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_seq_o(out_seq), .level_o(level), .full_o(full),
    .overflow_cnt_o(ovf_cnt), .seq_err_o(seq_err), .err_clr_i(err_clr)
  );

  rd_resp_buffer #(.DEPTH(8), .DATA_W(32), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_valid_i(b_valid), .rd_data_i(b_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_ready), .out_data_o(b_out_data),
    .out_seq_o(b_out_seq), .level_o(b_level), .full_o(b_full),
    .overflow_cnt_o(b_ovf_cnt), .seq_err_o(b_seq_err), .err_clr_i(b_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, leaving time to settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    rd_valid = 1'b1;
    rd_data  = d;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_seq", 64'(out_seq), 64'(0));
    chk("rst_ovf", 64'(ovf_cnt), 64'(0));
    chk("rst_err", 64'(seq_err), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single beat, then pop
    beat(32'h5);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_data", 64'(out_data), 64'h5);
    chk("single_seq", 64'(out_seq), 64'(0));
    chk("single_level", 64'(level), 64'(1));
    pop_one();
    chk("single_pop_level", 64'(level), 64'(0));
    chk("single_pop_data", 64'(out_data), 64'(0));

    // Fill and overflow
    do_reset();
    for (int i = 0; i < 10; i++) beat(32'(i));
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_level", 64'(level), 64'(8));
    chk("fill_ovf", 64'(ovf_cnt), 64'(2));
    chk("fill_err", 64'(seq_err), 64'(0));
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 64'(out_data), 64'(i));
      chk("drain_seq", 64'(out_seq), 64'(i));
      pop_one();
    end
    chk("drain_empty", 64'(out_valid), 64'(0));
    beat(32'd10);
    chk("after_drop_seq", 64'(out_seq), 64'(10));
    chk("after_drop_data", 64'(out_data), 64'(10));
    pop_one();

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) beat(32'(i));
    chk("pp_full", 64'(full), 64'(1));
    out_ready = 1'b1;
    beat(32'd8);
    out_ready = 1'b0;
    chk("pp_level", 64'(level), 64'(8));
    chk("pp_full_after", 64'(full), 64'(1));
    chk("pp_ovf", 64'(ovf_cnt), 64'(0));
    for (int i = 1; i <= 8; i++) begin
      chk("pp_drain_data", 64'(out_data), 64'(i));
      chk("pp_drain_seq", 64'(out_seq), 64'(i));
      pop_one();
    end
    chk("pp_drained", 64'(level), 64'(0));

    // Progression check
    do_reset();
    beat(32'h10);
    beat(32'h10);
    beat(32'h11);
    chk("prog_ok", 64'(seq_err), 64'(0));
    beat(32'h13);
    chk("prog_set", 64'(seq_err), 64'(1));
    beat(32'h14);
    chk("prog_sticky", 64'(seq_err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("prog_clr", 64'(seq_err), 64'(0));
    chk("prog_clr_keeps_fifo", 64'(level), 64'(5));
    do_reset();
    beat(32'hFFFF_FFFF);
    beat(32'h0);
    chk("prog_wrap", 64'(seq_err), 64'(0));
    err_clr = 1'b1;
    beat(32'h5);
    err_clr = 1'b0;
    chk("prog_clr_vs_evt", 64'(seq_err), 64'(1));

    // Saturation and clear priority on the 4-bit instance
    do_reset();
    b_valid = 1'b1;
    for (int i = 0; i < 28; i++) tick();
    chk("sat_full", 64'(b_full), 64'(1));
    chk("sat_cnt", 64'(b_ovf_cnt), 64'hF);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    b_valid = 1'b0;
    chk("sat_clr_drop", 64'(b_ovf_cnt), 64'(1));
    chk("sat_no_err", 64'(b_seq_err), 64'(0));
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("sat_clr", 64'(b_ovf_cnt), 64'(0));

    // Long stream with tag wrap, then reset mid-stream
    do_reset();
    out_ready = 1'b1;
    rd_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rd_data = 32'(i);
      tick();
      if (i == 299) out_ready = 1'b0;
      chk("stream_seq", 64'(out_seq), 64'(i % 256));
      chk("stream_data", 64'(out_data), 64'(i));
    end
    rd_valid = 1'b0;
    chk("stream_ovf", 64'(ovf_cnt), 64'(0));
    chk("stream_err", 64'(seq_err), 64'(0));
    beat(32'd300);
    beat(32'd301);
    chk("mid_level", 64'(level), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    beat(32'h1234);
    chk("post_rst_seq", 64'(out_seq), 64'(0));
    chk("post_rst_data", 64'(out_data), 64'h1234);
    chk("post_rst_err", 64'(seq_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
